round_sequencer: RTL
====================

Name: round_sequencer

Overview:
Game-round controller that sequences the button/LED scoring datapath. Each round it generates a 3-bit LED target pattern from an LFSR and displays it for a fixed time. It then opens a timed response window, latches the player's buttons on submit or timeout, and issues a one-cycle evaluate strobe to the scoring logic. After a fixed number of rounds it ends the game.

Parameters:
SHOW_CYCLES, 25000000, number of cycles the pattern is shown on led (>=1)
WINDOW_CYCLES, 50000000, number of cycles in the response window (>=1)
ROUNDS, 10, rounds per game (1..2^ROUND_W)
ROUND_W, 4, width of round_cnt
LFSR_SEED, 3'b001, LFSR reset value; if 0, 3'b001 is loaded instead

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-low (rst==0 resets on the clock edge)
start  input  1  start-game request, sampled in IDLE/DONE only
submit  input  1  player submit, already debounced/synchronised, sampled in INPUT only
btn  input  3  player button levels (bit0=b1, bit1=b2, bit2=b3)
led  output  3  LEDs driven to the player
pattern  output  3  current round target, held for the scorer
btn_latched  output  3  buttons captured at submit/timeout
eval_go  output  1  one-cycle strobe: pattern/btn_latched valid for scoring
timeout  output  1  one-cycle, coincident with eval_go when the window expired
round_cnt  output  ROUND_W  zero-based index of the current round
busy  output  1  high in SHOW/INPUT/EVAL
game_over  output  1  high in DONE

Behaviour:
- Reset (rst==0 at an edge): state=IDLE. led, pattern, btn_latched, round_cnt, eval_go, timeout, busy, game_over are all 0. lfsr=LFSR_SEED (001 if seed 0). Timer=0. Reset mid-game aborts immediately; no eval_go is issued.
- LFSR: 3-bit, next = {q[1:0], q[2]^q[1]}, period 7, never 000. From 001 the sequence is 001,010,101,011,111,110,100. The LFSR is not reset by start, so successive games differ.
- IDLE: start=1 -> SHOW. Set pattern=lfsr, round_cnt=0, timer=0.
- SHOW: led=pattern, busy=1. Timer counts 0..SHOW_CYCLES-1. At terminal count -> INPUT, timer=0. led=0 from the first INPUT cycle.
- INPUT: led=0, busy=1. Timer counts 0..WINDOW_CYCLES-1.
  - submit=1 -> btn_latched<=btn, go to EVAL.
  - Else, at terminal count -> btn_latched<=000, timeout flag set, go to EVAL.
  - submit on the terminal-count cycle: submit wins, timeout stays 0.
- EVAL: exactly one cycle. eval_go=1, and timeout=1 if the window expired. pattern and btn_latched are stable.
  - If round_cnt==ROUNDS-1 -> DONE.
  - Else round_cnt+1, lfsr advances, pattern<=advanced lfsr value, timer=0 -> SHOW.
- DONE: game_over=1, busy=0, led=0. pattern, btn_latched and round_cnt hold. start=1 -> restart as from IDLE (round_cnt=0, pattern=lfsr advanced once from its last value, game_over=0).
- pattern changes only on entry to SHOW. btn_latched changes only on exit from INPUT.
- start is ignored while busy. submit is ignored outside INPUT. btn is don't-care outside the INPUT exit cycle.
- Latency:
  - start accepted at edge N -> led valid after edge N.
  - submit at edge M -> eval_go high during the cycle after edge M.
- Round length without submit: SHOW_CYCLES+WINDOW_CYCLES+1 cycles.
- All outputs are registered.

Test Plan:
(All scenarios: SHOW_CYCLES=4, WINDOW_CYCLES=8, ROUNDS=3, LFSR_SEED=001.)
1. Release reset, pulse start -> led=001 for exactly 4 cycles, then led=000; busy=1; round_cnt=0.
2. In INPUT, btn=101 with submit pulse -> next cycle eval_go=1, btn_latched=101, pattern=001, timeout=0; following cycle led=010, round_cnt=1.
3. In INPUT, no submit, btn=111 -> after 8 INPUT cycles eval_go=1, timeout=1, btn_latched=000; both strobes last exactly one cycle.
4. Full game with submits -> patterns 001,010,101 and three eval_go pulses; then game_over=1, busy=0, round_cnt=2 held; start -> pattern=011, round_cnt=0.
5. Submit asserted on the 8th INPUT cycle with btn=011 -> eval_go=1, timeout=0, btn_latched=011.
6. rst=0 during INPUT of round 1 -> next edge: all outputs 0, IDLE, no eval_go. After release, start -> pattern=001. Start pulsed during SHOW -> no effect on timer/round_cnt.

Source files
------------

// File: rtl/round_sequencer.sv
// Game-round controller: shows an LFSR target pattern, opens a timed response
// window, latches the buttons and strobes the scorer once per round.
module round_sequencer #(
  parameter int         SHOW_CYCLES   = 25000000,
  parameter int         WINDOW_CYCLES = 50000000,
  parameter int         ROUNDS        = 10,
  parameter int         ROUND_W       = 4,
  parameter logic [2:0] LFSR_SEED     = 3'b001
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               submit,
  input  logic [2:0]         btn,
  output logic [2:0]         led,
  output logic [2:0]         pattern,
  output logic [2:0]         btn_latched,
  output logic               eval_go,
  output logic               timeout,
  output logic [ROUND_W-1:0] round_cnt,
  output logic               busy,
  output logic               game_over,
  output logic [2:0]         state_dbg
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHOW  = 3'd1,
    ST_INPUT = 3'd2,
    ST_EVAL  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int MAXC = (SHOW_CYCLES > WINDOW_CYCLES) ? SHOW_CYCLES : WINDOW_CYCLES;
  localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [TW-1:0]      SHOW_LAST   = TW'(SHOW_CYCLES - 1);
  localparam logic [TW-1:0]      WINDOW_LAST = TW'(WINDOW_CYCLES - 1);
  localparam logic [ROUND_W-1:0] ROUND_LAST  = ROUND_W'(ROUNDS - 1);
  // An all-zero seed would lock the LFSR, so substitute 001.
  localparam logic [2:0]         SEED        = (LFSR_SEED == 3'b000) ? 3'b001 : LFSR_SEED;

  function automatic logic [2:0] lfsr_step(input logic [2:0] q);
    return {q[1:0], q[2] ^ q[1]};
  endfunction

  state_t             state_q, state_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [2:0]         lfsr_q, lfsr_d;
  logic [2:0]         pattern_q, pattern_d;
  logic [2:0]         btn_latched_q, btn_latched_d;
  logic [ROUND_W-1:0] round_q, round_d;
  logic               expired_d;
  logic [2:0]         led_q;
  logic               eval_go_q, timeout_q, busy_q, game_over_q;

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    lfsr_d        = lfsr_q;
    pattern_d     = pattern_q;
    btn_latched_d = btn_latched_q;
    round_d       = round_q;
    expired_d     = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          // A restart from DONE draws a fresh pattern; a cold start uses the seed.
          if (state_q == ST_DONE) lfsr_d = lfsr_step(lfsr_q);
          pattern_d = lfsr_d;
          round_d   = '0;
          timer_d   = '0;
          state_d   = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (timer_q == SHOW_LAST) begin
          timer_d = '0;
          state_d = ST_INPUT;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_INPUT: begin
        if (submit) begin
          btn_latched_d = btn;
          state_d       = ST_EVAL;
        end else if (timer_q == WINDOW_LAST) begin
          btn_latched_d = 3'b000;
          expired_d     = 1'b1;
          state_d       = ST_EVAL;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_EVAL: begin
        if (round_q == ROUND_LAST) begin
          state_d = ST_DONE;
        end else begin
          round_d   = round_q + ROUND_W'(1);
          lfsr_d    = lfsr_step(lfsr_q);
          pattern_d = lfsr_d;
          timer_d   = '0;
          state_d   = ST_SHOW;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so they line up with the state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      timer_q       <= '0;
      lfsr_q        <= SEED;
      pattern_q     <= 3'b000;
      btn_latched_q <= 3'b000;
      round_q       <= '0;
      led_q         <= 3'b000;
      eval_go_q     <= 1'b0;
      timeout_q     <= 1'b0;
      busy_q        <= 1'b0;
      game_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      lfsr_q        <= lfsr_d;
      pattern_q     <= pattern_d;
      btn_latched_q <= btn_latched_d;
      round_q       <= round_d;
      led_q         <= (state_d == ST_SHOW) ? pattern_d : 3'b000;
      eval_go_q     <= (state_d == ST_EVAL);
      timeout_q     <= expired_d;
      busy_q        <= (state_d == ST_SHOW) || (state_d == ST_INPUT) || (state_d == ST_EVAL);
      game_over_q   <= (state_d == ST_DONE);
    end
  end

  assign led         = led_q;
  assign pattern     = pattern_q;
  assign btn_latched = btn_latched_q;
  assign eval_go     = eval_go_q;
  assign timeout     = timeout_q;
  assign round_cnt   = round_q;
  assign busy        = busy_q;
  assign game_over   = game_over_q;
  assign state_dbg   = state_q;

endmodule
